// File: rtl/gpio_writer_if.sv
// gpio_writer_if: CPU write bus, A/C/DAC stream masters and config outputs of gpio_writer.
// slave is the gpio_writer side; master is the CPU/stream-sink side.
interface gpio_writer_if #(parameter int num_bits = 8);
    logic [31:0]         gpio_in;
    logic                gpio_ack;
    logic [num_bits-1:0] a_data;
    logic                a_valid;
    logic                a_ready;
    logic [num_bits-1:0] c_data;
    logic                c_valid;
    logic                c_ready;
    logic [127:0]        dac_data;
    logic                dac_valid;
    logic                dac_ready;
    logic [15:0]         cfg0;
    logic [15:0]         cfg1;
    logic [15:0]         cfg2;
    logic [15:0]         cfg3;
    logic                start_pulse;

    modport slave (
        input  gpio_in, a_ready, c_ready, dac_ready,
        output gpio_ack, a_data, a_valid, c_data, c_valid, dac_data, dac_valid,
               cfg0, cfg1, cfg2, cfg3, start_pulse
    );

    modport master (
        output gpio_in, a_ready, c_ready, dac_ready,
        input  gpio_ack, a_data, a_valid, c_data, c_valid, dac_data, dac_valid,
               cfg0, cfg1, cfg2, cfg3, start_pulse
    );
endinterface

// File: rtl/gpio_writer.sv
// gpio_writer: decodes CPU GPIO writes into A/C streams, a 128-bit DAC word, config regs and a start pulse.
// Define GPIO_WRITER_DAC_EN to build the DAC slice accumulator (addresses 0x03/0x04).
module gpio_writer #(
    parameter int num_bits = 8
) (
    input  logic         clk,
    input  logic         rst,
    gpio_writer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RDY, ACK} state_t;

    state_t              r_state;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_sync3;
    logic [1:0]          r_fill;
    logic                r_armed;
    logic [7:0]          r_addr;
    logic [15:0]         r_data;
    logic                r_ack;
    logic [num_bits-1:0] r_aData;
    logic [num_bits-1:0] r_cData;
    logic                r_aValid;
    logic                r_cValid;
    logic [15:0]         r_cfg [4];
    logic                r_start;
    logic                w_rise;
    logic                w_dacValid;
    logic                w_handshake;

`ifdef GPIO_WRITER_DAC_EN
    logic [127:0]        r_acc;
    logic [2:0]          r_cnt;
    logic                r_dacValid;

    assign w_dacValid   = r_dacValid;
    assign bus.dac_data = r_acc;
`else
    assign w_dacValid   = 1'b0;
    assign bus.dac_data = '0;
`endif

    // r_armed blocks a w_clk that was already high across reset until it is seen low
    assign w_rise      = r_sync2 & ~r_sync3 & r_armed;
    assign w_handshake = (r_aValid & bus.a_ready) | (r_cValid & bus.c_ready) |
                         (w_dacValid & bus.dac_ready);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync3  <= 1'b0;
            r_fill   <= 2'b00;
            r_armed  <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_ack    <= 1'b0;
            r_aData  <= '0;
            r_cData  <= '0;
            r_aValid <= 1'b0;
            r_cValid <= 1'b0;
            r_start  <= 1'b0;
            for (int i = 0; i < 4; i++) r_cfg[i] <= '0;
`ifdef GPIO_WRITER_DAC_EN
            r_acc      <= '0;
            r_cnt      <= '0;
            r_dacValid <= 1'b0;
`endif
        end else begin
            r_sync1 <= bus.gpio_in[31];
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_fill  <= {r_fill[0], 1'b1};
            if (r_fill[1] && !r_sync2) r_armed <= 1'b1;
            r_start <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_addr  <= bus.gpio_in[23:16];
                        r_data  <= bus.gpio_in[15:0];
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_state <= ACK;
                    r_ack   <= 1'b1;
                    case (r_addr)
                        8'h01: begin
                            r_aData  <= r_data[num_bits-1:0];
                            r_aValid <= 1'b1;
                            r_state  <= WAIT_RDY;
                            r_ack    <= 1'b0;
                        end
                        8'h02: begin
                            r_cData  <= r_data[num_bits-1:0];
                            r_cValid <= 1'b1;
                            r_state  <= WAIT_RDY;
                            r_ack    <= 1'b0;
                        end
`ifdef GPIO_WRITER_DAC_EN
                        8'h03: begin
                            r_acc[{r_cnt, 4'b0000} +: 16] <= r_data;
                            r_cnt <= r_cnt + 3'd1;
                            if (r_cnt == 3'd7) begin
                                r_dacValid <= 1'b1;
                                r_state    <= WAIT_RDY;
                                r_ack      <= 1'b0;
                            end
                        end
                        8'h04: begin
                            r_acc <= '0;
                            r_cnt <= '0;
                        end
`endif
                        8'h10, 8'h11, 8'h12, 8'h13: r_cfg[r_addr[1:0]] <= r_data;
                        8'h14: r_start <= 1'b1;
                        default: ;
                    endcase
                end
                WAIT_RDY: begin
                    if (w_handshake) begin
                        r_aValid <= 1'b0;
                        r_cValid <= 1'b0;
`ifdef GPIO_WRITER_DAC_EN
                        r_dacValid <= 1'b0;
`endif
                        r_ack   <= 1'b1;
                        r_state <= ACK;
                    end
                end
                ACK: begin
                    if (!r_sync2) begin
                        r_ack   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gpio_ack    = r_ack;
    assign bus.a_data      = r_aData;
    assign bus.a_valid     = r_aValid;
    assign bus.c_data      = r_cData;
    assign bus.c_valid     = r_cValid;
    assign bus.dac_valid   = w_dacValid;
    assign bus.cfg0        = r_cfg[0];
    assign bus.cfg1        = r_cfg[1];
    assign bus.cfg2        = r_cfg[2];
    assign bus.cfg3        = r_cfg[3];
    assign bus.start_pulse = r_start;
endmodule
